// File: rtl/irq_priority_engine.sv
// irq_priority_engine
//
// Registered interrupt priority engine. It holds the interrupt request
// register (irr), the in-service register (isr) and the rotation pointer
// (lowest_prio) for NUM_IRQ channels. Each cycle it picks the winning
// request under fully nested or special-mask rules. It also runs the CPU
// acknowledge and end-of-interrupt (EOI) handshake.
//
// Ports
//   clock, reset_n            system clock, asynchronous active-low reset
//   irq_in                    raw request lines
//   edge_mode                 1: irr latches rising edges, 0: irr follows level
//   mask                      per-channel mask (1 = masked)
//   special_mask_mode         1: an isr bit blocks only its own channel
//   auto_rotate               1: the channel cleared by EOI becomes lowest priority
//   set_prio_valid/_id        specific rotation, set_prio_id becomes lowest priority
//   eoi_valid/_specific/_id   end of interrupt, specific or non-specific
//   ack_valid                 CPU acknowledge pulse
//   int_req, int_id           registered request flag and winning channel
//   ack_done, ack_id,         acknowledge response, one cycle after ack_valid
//   ack_spurious
//   irr, isr, lowest_prio     register state
//
// Configuration macro
//   IRQ_PRIORITY_ENGINE_SYNC_EN : when defined, irq_in passes through a
//   two-flop synchroniser before sampling. This adds two edges of request
//   latency.

module irq_priority_engine #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               edge_mode,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               special_mask_mode,
  input  logic               auto_rotate,
  input  logic               set_prio_valid,
  input  logic [ID_W-1:0]    set_prio_id,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_id,
  input  logic               ack_valid,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic               ack_done,
  output logic [ID_W-1:0]    ack_id,
  output logic               ack_spurious,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    lowest_prio
);

  // Return the one-hot vector for channel id.
  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_IRQ-1:0] one;
    one = {{(NUM_IRQ-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

  // Return the highest-priority set bit of vec as {found, index}.
  // Priority starts at low+1 and wraps. The scan runs from lowest to
  // highest priority, so the final hit is the winner.
  function automatic logic [ID_W:0] top_bit(input logic [NUM_IRQ-1:0] vec,
                                            input logic [ID_W-1:0]    low);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx = low + ID_W'(1) + ID_W'(i);
      res = vec[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  logic [NUM_IRQ-1:0] irq_smp;

`ifdef IRQ_PRIORITY_ENGINE_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  // Two-flop synchroniser for asynchronous request lines.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_smp = sync2_q;
`else
  assign irq_smp = irq_in;
`endif

  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [ID_W-1:0]    lowest_q, lowest_d;
  logic               int_req_q, int_req_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic               ack_done_q, ack_done_d;
  logic [ID_W-1:0]    ack_id_q, ack_id_d;
  logic               ack_spur_q, ack_spur_d;

  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W:0]      win_top;
  logic [ID_W:0]      isr_top;
  logic [ID_W-1:0]    win_rank;
  logic [ID_W-1:0]    isr_rank;
  logic               ack_take;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eoi_mask;
  logic [ID_W-1:0]    eoi_bit;

  // Next-state logic: winner selection, IRR/ISR update, rotation and ack response.
  always_comb begin
    eligible = irr_q & ~mask & ~isr_q;
    win_top  = top_bit(eligible, lowest_q);
    isr_top  = top_bit(isr_q, lowest_q);
    // Rank 0 is the highest priority. Wrap-around subtraction gives the
    // distance from the highest-priority slot.
    win_rank = win_top[ID_W-1:0] - lowest_q - ID_W'(1);
    isr_rank = isr_top[ID_W-1:0] - lowest_q - ID_W'(1);

    if (!win_top[ID_W]) begin
      int_req_d = 1'b0;
    end else if (special_mask_mode || !isr_top[ID_W]) begin
      int_req_d = 1'b1;
    end else begin
      int_req_d = (win_rank < isr_rank);
    end
    // int_id tracks the top eligible channel even when nesting blocks int_req.
    int_id_d = win_top[ID_W-1:0];

    // The acknowledge applies to the channel that was presented on int_id.
    ack_take = ack_valid & int_req_q;
    if (ack_take) begin
      ack_mask = onehot(int_id_q);
    end else begin
      ack_mask = '0;
    end

    rise = irq_smp & ~irq_prev_q;
    if (edge_mode) begin
      // A new edge wins over an acknowledge clear of the same bit.
      irr_d = (irr_q & ~ack_mask) | rise;
    end else begin
      irr_d = irq_smp & ~ack_mask;
    end

    // EOI uses the pre-edge ISR.
    if (!eoi_valid) begin
      eoi_mask = '0;
      eoi_bit  = '0;
    end else if (eoi_specific) begin
      eoi_mask = isr_q & onehot(eoi_id);
      eoi_bit  = eoi_id;
    end else if (isr_top[ID_W]) begin
      eoi_mask = onehot(isr_top[ID_W-1:0]);
      eoi_bit  = isr_top[ID_W-1:0];
    end else begin
      eoi_mask = '0;
      eoi_bit  = '0;
    end
    // An acknowledge setting the bit that EOI clears leaves it set.
    isr_d = (isr_q & ~eoi_mask) | ack_mask;

    if (set_prio_valid) begin
      lowest_d = set_prio_id;
    end else if (auto_rotate && (eoi_mask != '0)) begin
      lowest_d = eoi_bit;
    end else begin
      lowest_d = lowest_q;
    end

    ack_done_d = ack_valid;
    ack_spur_d = ack_valid & ~int_req_q;
    if (!ack_valid) begin
      ack_id_d = ack_id_q;
    end else if (int_req_q) begin
      ack_id_d = int_id_q;
    end else begin
      ack_id_d = ID_W'(NUM_IRQ - 1);
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irr_q      <= '0;
      isr_q      <= '0;
      irq_prev_q <= '0;
      lowest_q   <= ID_W'(NUM_IRQ - 1);
      int_req_q  <= 1'b0;
      int_id_q   <= '0;
      ack_done_q <= 1'b0;
      ack_id_q   <= '0;
      ack_spur_q <= 1'b0;
    end else begin
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_smp;
      lowest_q   <= lowest_d;
      int_req_q  <= int_req_d;
      int_id_q   <= int_id_d;
      ack_done_q <= ack_done_d;
      ack_id_q   <= ack_id_d;
      ack_spur_q <= ack_spur_d;
    end
  end

  assign int_req      = int_req_q;
  assign int_id       = int_id_q;
  assign ack_done     = ack_done_q;
  assign ack_id       = ack_id_q;
  assign ack_spurious = ack_spur_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign lowest_prio  = lowest_q;

endmodule

// File: tb/tb_irq_priority_engine.sv
// Testbench for irq_priority_engine (NUM_IRQ=8, default build).
// Directed scenarios plus randomized traffic checked against a behavioural
// model. The model ranks channels by rotation distance.

module tb_irq_priority_engine;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          edge_mode = 1'b1;
  logic [N-1:0]  mask = '0;
  logic          special_mask_mode = 1'b0;
  logic          auto_rotate = 1'b0;
  logic          set_prio_valid = 1'b0;
  logic [IW-1:0] set_prio_id = '0;
  logic          eoi_valid = 1'b0;
  logic          eoi_specific = 1'b0;
  logic [IW-1:0] eoi_id = '0;
  logic          ack_valid = 1'b0;
  logic          int_req;
  logic [IW-1:0] int_id;
  logic          ack_done;
  logic [IW-1:0] ack_id;
  logic          ack_spurious;
  logic [N-1:0]  irr;
  logic [N-1:0]  isr;
  logic [IW-1:0] lowest_prio;

  int checks = 0;
  int failures = 0;

  irq_priority_engine #(.NUM_IRQ(N)) dut (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .edge_mode(edge_mode),
    .mask(mask), .special_mask_mode(special_mask_mode), .auto_rotate(auto_rotate),
    .set_prio_valid(set_prio_valid), .set_prio_id(set_prio_id),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_id(eoi_id),
    .ack_valid(ack_valid), .int_req(int_req), .int_id(int_id),
    .ack_done(ack_done), .ack_id(ack_id), .ack_spurious(ack_spurious),
    .irr(irr), .isr(isr), .lowest_prio(lowest_prio)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit [N-1:0] m_irr, m_isr, m_prev;
  int         m_low, m_id, m_ack_id;
  bit         m_req, m_done, m_spur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Distance from the highest-priority slot; 0 = highest.
  function automatic int rank(input int k, input int low);
    return (k - low - 1 + N) % N;
  endfunction

  function automatic int best_of(input bit [N-1:0] v, input int low);
    int b = -1;
    for (int k = 0; k < N; k++)
      if (v[k] && (b < 0 || rank(k, low) < rank(b, low))) b = k;
    return b;
  endfunction

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_prev = '0; m_low = N - 1;
    m_req = 0; m_id = 0; m_done = 0; m_ack_id = 0; m_spur = 0;
  endtask

  task automatic model_edge();
    bit [N-1:0] elig, irr_n, isr_n;
    int best, top, ak, clr, low_n;
    bit ack_real, req_n;
    elig = m_irr & ~mask & ~m_isr;
    best = best_of(elig, m_low);
    top  = best_of(m_isr, m_low);
    req_n = (best >= 0) && (special_mask_mode || top < 0 || rank(best, m_low) < rank(top, m_low));
    ack_real = ack_valid && m_req;
    ak = m_req ? m_id : N - 1;
    clr = -1;
    if (eoi_valid) begin
      if (eoi_specific) clr = m_isr[eoi_id] ? int'(eoi_id) : -1;
      else clr = top;
    end
    for (int k = 0; k < N; k++) begin
      if (edge_mode)
        irr_n[k] = (irq_in[k] && !m_prev[k]) || (m_irr[k] && !(ack_real && k == ak));
      else
        irr_n[k] = irq_in[k] && !(ack_real && k == ak);
      isr_n[k] = (m_isr[k] && k != clr) || (ack_real && k == ak);
    end
    low_n = set_prio_valid ? int'(set_prio_id) : ((auto_rotate && clr >= 0) ? clr : m_low);
    if (ack_valid) m_ack_id = ak;
    m_done = ack_valid;
    m_spur = ack_valid && !m_req;
    m_req = req_n;
    m_id = (best >= 0) ? best : 0;
    m_prev = irq_in;
    m_irr = irr_n;
    m_isr = isr_n;
    m_low = low_n;
  endtask

  task automatic compare_all();
    check_eq("int_req", int_req, m_req);
    if (m_req) check_eq("int_id", int_id, m_id);
    check_eq("ack_done", ack_done, m_done);
    if (m_done) check_eq("ack_id", ack_id, m_ack_id);
    check_eq("ack_spurious", ack_spurious, m_spur);
    check_eq("irr", irr, m_irr);
    check_eq("isr", isr, m_isr);
    check_eq("lowest_prio", lowest_prio, m_low);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic clear_inputs();
    irq_in = '0; edge_mode = 1'b1; mask = '0; special_mask_mode = 1'b0;
    auto_rotate = 1'b0; set_prio_valid = 1'b0; set_prio_id = '0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = '0; ack_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_int_req"}, int_req, 0);
    check_eq({tag, "_int_id"}, int_id, 0);
    check_eq({tag, "_ack_done"}, ack_done, 0);
    check_eq({tag, "_ack_id"}, ack_id, 0);
    check_eq({tag, "_ack_spurious"}, ack_spurious, 0);
    check_eq({tag, "_irr"}, irr, 0);
    check_eq({tag, "_isr"}, isr, 0);
    check_eq({tag, "_lowest"}, lowest_prio, N - 1);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    check_reset_values("rst");
    reset_n = 1'b1;
  endtask

  // Present v on irq_in for one edge.
  task automatic pulse(input logic [N-1:0] v);
    irq_in = v; step(); irq_in = '0;
  endtask

  task automatic ack_once();
    ack_valid = 1'b1; step(); ack_valid = 1'b0;
  endtask

  initial begin
    // Test 1: basic edge request, ack, non-specific EOI
    do_reset();
    pulse(8'h28); step();
    check_eq("t1_req", int_req, 1); check_eq("t1_id", int_id, 3);
    ack_once();
    check_eq("t1_ack_done", ack_done, 1); check_eq("t1_ack_id", ack_id, 3);
    check_eq("t1_isr", isr, 8'h08);
    step();
    check_eq("t1_id5_blocked", int_id, 5); check_eq("t1_req_blocked", int_req, 0);
    eoi_valid = 1'b1; eoi_specific = 1'b0; step(); eoi_valid = 1'b0;
    check_eq("t1_isr_eoi", isr, 8'h00);
    step();
    check_eq("t1_req_after_eoi", int_req, 1); check_eq("t1_id_after_eoi", int_id, 5);

    // Test 2: fully nested
    do_reset();
    pulse(8'h04); step(); ack_once(); step();
    check_eq("t2_isr", isr, 8'h04);
    pulse(8'h41); step();
    check_eq("t2_req", int_req, 1); check_eq("t2_id", int_id, 0);
    ack_once(); step();
    check_eq("t2_nested_req0", int_req, 0);
    eoi_valid = 1'b1; step(); eoi_valid = 1'b0;
    check_eq("t2_isr_eoi1", isr, 8'h04);
    step();
    check_eq("t2_req_after_eoi1", int_req, 0);
    eoi_valid = 1'b1; step(); eoi_valid = 1'b0;
    check_eq("t2_isr_eoi2", isr, 8'h00);
    step();
    check_eq("t2_req_after_eoi2", int_req, 1); check_eq("t2_id_after_eoi2", int_id, 6);

    // Test 3: auto rotation
    do_reset();
    auto_rotate = 1'b1;
    pulse(8'h01); step(); ack_once();
    eoi_valid = 1'b1; step(); eoi_valid = 1'b0;
    check_eq("t3_lowest", lowest_prio, 0);
    pulse(8'h03); step();
    check_eq("t3_req", int_req, 1); check_eq("t3_id", int_id, 1);

    // Test 4: set_prio overrides auto-rotation
    do_reset();
    auto_rotate = 1'b1;
    pulse(8'h04); step(); ack_once();
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_id = 3'd2;
    set_prio_valid = 1'b1; set_prio_id = 3'd4;
    step();
    eoi_valid = 1'b0; eoi_specific = 1'b0; set_prio_valid = 1'b0;
    check_eq("t4_lowest", lowest_prio, 4); check_eq("t4_isr", isr, 0);
    pulse(8'h28); step();
    check_eq("t4_req", int_req, 1); check_eq("t4_id", int_id, 5);

    // Test 5: spurious acknowledge
    do_reset();
    ack_once();
    check_eq("t5_ack_done", ack_done, 1); check_eq("t5_spur", ack_spurious, 1);
    check_eq("t5_ack_id", ack_id, 7); check_eq("t5_isr", isr, 0);

    // Test 6: special mask mode, then reset mid-acknowledge
    do_reset();
    special_mask_mode = 1'b1;
    pulse(8'h01); step(); ack_once(); step();
    check_eq("t6_isr", isr, 8'h01);
    pulse(8'h09); step();
    check_eq("t6_req", int_req, 1); check_eq("t6_id", int_id, 3);
    ack_valid = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("t6_midack");
    ack_valid = 1'b0;
    @(posedge clock);
    #1;
    check_eq("t6_no_ack_done", ack_done, 0);
    model_reset();
    clear_inputs();
    reset_n = 1'b1;
    step(); step();

    // Randomized traffic in random mode combinations
    for (int b = 0; b < 8; b++) begin
      do_reset();
      edge_mode = 1'($urandom_range(1, 0));
      special_mask_mode = 1'($urandom_range(1, 0));
      auto_rotate = 1'($urandom_range(1, 0));
      for (int c = 0; c < 400; c++) begin
        irq_in = N'($urandom & $urandom & $urandom);
        mask = N'($urandom & $urandom & $urandom);
        ack_valid = ($urandom_range(3, 0) == 0);
        eoi_valid = ($urandom_range(4, 0) == 0);
        eoi_specific = 1'($urandom_range(1, 0));
        eoi_id = IW'($urandom_range(N - 1, 0));
        set_prio_valid = ($urandom_range(15, 0) == 0);
        set_prio_id = IW'($urandom_range(N - 1, 0));
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
